// File: rtl/encode_pri_seq.sv
// Registered priority encoder with pending-request capture.
// Fixed-priority or round-robin grant, valid/ready output stage.
module encode_pri_seq #(
    parameter int N    = 8,
    parameter int W    = $clog2(N),
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] I,
    input  logic         ready,
    output logic [W-1:0] Y,
    output logic         V,
    output logic         ovf
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [N-1:0] p;
    logic [N-1:0] r;
    logic [N-1:0] mask;
    logic [N-1:0] rh;
    logic [N-1:0] src;
    logic [N-1:0] gnt;
    logic [N-1:0] p_next;
    logic [W-1:0] sel;
    logic [W-1:0] last_grant;
    logic         load;
    logic         hit;
    logic         ovf_next;

    assign r    = p | I;
    assign hit  = |r;
    assign load = ~V | ready;

    // Pick the winning index: lowest set bit, or in round-robin mode the
    // lowest set bit above the last grant, wrapping to the lowest overall.
    always_comb begin
        mask = '0;
        for (int k = 0; k < N; k++) begin
            mask[k] = (k > int'(last_grant));
        end
        rh  = r & mask;
        src = ((MODE != 0) && (|rh)) ? rh : r;
        sel = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (src[k]) begin
                sel = W'(k);
            end
        end
    end

    // Clear the granted bit unless it was pending and re-requested now;
    // a fresh request consumed by its own grant does not linger.
    always_comb begin
        gnt      = (load && hit) ? (ONE << sel) : '0;
        p_next   = (p & ~gnt) | (I & ~(gnt & ~p));
        ovf_next = |(I & p & ~gnt);
    end

    // Pending vector, output register, overflow pulse and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p          <= '0;
            Y          <= '0;
            V          <= 1'b0;
            ovf        <= 1'b0;
            last_grant <= W'(N - 1);
        end else begin
            p   <= p_next;
            ovf <= ovf_next;
            if (load) begin
                if (hit) begin
                    Y          <= sel;
                    V          <= 1'b1;
                    last_grant <= sel;
                end else begin
                    V <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/encode_pri_seq.md
ENCODE_PRI_SEQ -- requirements
Module: encode_pri_seq

Interface
REQ-001 Parameter N, default 8: number of request inputs; legal range 2..64.
REQ-002 Parameter W, default $clog2(N): output index width; derived, not overridden.
REQ-003 Parameter MODE, default 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 I  input  N  request pulses; each bit sampled every clk edge.
REQ-007 ready  input  1  consumer accepts the current output when ready=1 and V=1.
REQ-008 Y  output  W  encoded index of the granted request, registered.
REQ-009 V  output  1  output valid, registered; Y is meaningful only when V=1.
REQ-010 ovf  output  1  one-cycle pulse: a request arrived on a bit already pending.

Function
REQ-011 The block SHALL hold a pending vector P[N-1:0]; each edge, P_next = (P | I) with the granted bit cleared when a grant is loaded.
REQ-012 The effective request set each cycle SHALL be R = P | I, so a request on I is eligible in the same cycle it appears.
REQ-013 The output register SHALL load when (V=0 or ready=1): if R != 0, Y <= selected index, V <= 1, and that bit cleared from P_next; if R = 0, V <= 0 and Y holds.
REQ-014 When V=1 and ready=0, Y and V SHALL hold unchanged and no bit is cleared from P.
REQ-015 Latency: a request on I in cycle t with the output stage free SHALL give V=1 with the matching Y after the edge ending cycle t (1 cycle).
REQ-016 MODE=0: selected index SHALL be the lowest set bit of R.
REQ-017 MODE=1: selected index SHALL be the first set bit of R searching upward from (last_grant+1) mod N, wrapping from N-1 to 0; last_grant updates only on a load with R != 0.
REQ-018 If a bit of I is set and the same bit of P is already set (and is not granted in that cycle), ovf SHALL pulse 1 for the next cycle; the request is merged, not counted.
REQ-019 If a bit is granted in cycle t and the same bit of I is also set in cycle t, that bit SHALL remain set in P_next (set wins over clear) and ovf SHALL NOT pulse.
REQ-020 A held output (REQ-014) SHALL NOT block capture: new requests keep accumulating in P.
REQ-021 Back-to-back throughput: with ready=1 continuously and R != 0, one grant SHALL be produced per cycle.
REQ-022 Y SHALL never exceed N-1; indices are zero-based and match bit positions of I.

Reset
REQ-023 While rst_n=0: P = 0, Y = 0, V = 0, ovf = 0, last_grant = N-1 (so the first round-robin search starts at index 0).
REQ-024 Reset asserted mid-operation SHALL discard all pending requests and the held output immediately, without waiting for a clock edge.
REQ-025 The first edge after rst_n deasserts SHALL sample I normally; requests present during reset are not retained.

Verification (N=8)
REQ-026 MODE=0, ready=1, I=8'b0000_0100 for one cycle -> next cycle V=1, Y=2; the cycle after that V=0.
REQ-027 MODE=0, ready=1, I=8'b1001_0010 for one cycle -> Y=1, 4, 7 on three consecutive cycles with V=1, then V=0.
REQ-028 MODE=1, ready=1, I=8'hFF held for 10 cycles -> Y sequence 0,1,2,3,4,5,6,7,0,1; ovf pulses on every cycle in which a pending bit is requested again and not granted.
REQ-029 ready=0, I=8'b0000_0001 then 8'b0000_1000 -> V=1, Y=0 held; on ready=1, the next cycle shows Y=3.
REQ-030 ready=0 with bit 5 pending, I[5]=1 again -> ovf=1 for exactly one cycle; only one grant of 5 is later produced.
REQ-031 rst_n pulsed low while V=1 and P != 0 -> V, Y, P, ovf cleared asynchronously; no grants appear after release until new requests arrive.
